cpu_datapath: RTL and testbench
===============================

# cpu_datapath

32-bit bus-oriented CPU datapath: a single shared bus (BusMuxOut) links a general register file, special registers (PC, IR, MAR, MDR, HI, LO, Y, Z) and a combinational ALU. An external control unit or testbench sequences it one micro-operation per clock through discrete out/in strobes. The block is the execution core beneath the control FSM. Memory appears only as the Mdatain input into MDR.

## Interface
Parameters:
- DATA_W, 32, bus and register width.

Ports:
- Clock  in  1  system clock; all registers load on the rising edge.
- Clear  in  1  asynchronous, active-low reset.
- PCout, ZHighout, Zlowout, MDRout, R2out, R4out  in  1 each  bus-source selects.
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin  in  1 each  register load enables.
- R1in…R15in  in  1 each  general register load enables.
- ZHighIn, ZLowIn  in  1 each  load Z[63:32] / Z[31:0] from the ALU result.
- IncPC  in  1  ALU forces BusMuxOut + 1.
- Read  in  1  MDR input mux: 1 = Mdatain, 0 = BusMuxOut.
- Cin  in  1  ALU carry-in for ADD/SUB.
- OR  in  5  ALU operation select.
- Mdatain  in  32  memory read data.
- BusMuxOut  out  32  current bus value.

## Operation
- Bus mux (combinational, fixed priority): PCout > Zlowout > ZHighout > MDRout > R2out > R4out. With no source asserted the bus is 0.
- Register loads: Rn, PC, IR, MAR, Y, HI and LO take BusMuxOut when their in-strobe is high. MDR takes Mdatain when Read=1, otherwise BusMuxOut, whenever MDRin=1.
- ALU: A = Y, B = BusMuxOut, 64-bit result.
- IncPC=1 overrides OR: result = {32'b0, B+1}.
- Otherwise OR selects:
  - 00011 ADD A+B+Cin; 00100 SUB A−B−Cin (mod 2^32).
  - 00101 SHR logical; 00110 SHRA arithmetic; 00111 SHL. Shift amount is B[4:0].
  - 01000 ROR; 01001 ROL, both by B[4:0].
  - 01010 OR A|B; 01011 AND A&B.
  - 01100 NEG −B; 01101 NOT ~B.
  - Any other code gives 0.
- High half of the result is 0 for every operation.
- ZLowIn / ZHighIn load the corresponding halves independently.

## Timing
- Clear low (asynchronous): every register, including Z and both halves, goes to 0. BusMuxOut is therefore 0 until a register is loaded.
- BusMuxOut and the ALU result are purely combinational, settling in the same cycle.
- One transfer per cycle: a source drives the bus and the destination captures at the next rising edge.
- Read-then-capture takes 1 cycle: Mdatain becomes visible on the bus via MDRout in the cycle after MDRin/Read.
- Source and destination may be the same register, for example PCout with PCin. The old value is captured because of edge semantics.
- Multiple in-strobes in one cycle all load the same bus value.
- Clear deasserting mid-sequence: operation resumes at the next edge with all registers at 0.

## Configuration
- DATAPATH_ROTATE_EN:
  - Defined: ROR and ROL are implemented as specified.
  - Undefined: codes 01000 and 01001 yield 0, like any unused code.

## Structure
- Shared package cpu_datapath_pkg holds:
  - the 5-bit ALU opcode constants (ADD, SUB, SHR, SHRA, SHL, ROR, ROL, OR, AND, NEG, NOT);
  - DATA_W.
- Sub-module alu: inputs A, B, op, IncPC, Cin; 64-bit output.
- Bus mux, register file and special registers live in the top level.

## Test plan
- Register load: Mdatain=0x22, Read=1/MDRin=1 for one edge, then MDRout=1/R2in=1. R2out then shows 0x00000022 on BusMuxOut.
- OR instruction:
  - Preload R2=0x22, R4=0x24, R5=0x26.
  - R2out/Yin, then R4out/OR=01010/ZLowIn, then Zlowout/R5in.
  - Required: R5=0x26 and Z[63:32]=0.
- Fetch:
  - PC=0, then PCout/MARin/IncPC/ZLowIn, then Zlowout/PCin/Read/MDRin with Mdatain=0x4A920000, then MDRout/IRin.
  - Required: PC=1, MAR=0, IR=0x4A920000.
- ADD with carry: Y=0xFFFFFFFF, B=1, Cin=1, OR=00011. Required: Z low=0x00000001.
- Bus priority: PCout and MDRout both high with PC=5 and MDR=9. Required: BusMuxOut=5. All selects low gives 0.
- Async reset: Clear pulsed low between clock edges while registers are nonzero. Every register reads 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/cpu_datapath_pkg.sv
// cpu_datapath_pkg
// Shared definitions for the bus-oriented CPU datapath: the data width and
// the 5-bit ALU opcode constants decoded by the alu sub-module.
// Optional feature macro (used in alu.sv): DATAPATH_ROTATE_EN.
package cpu_datapath_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_AND  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b01100;
  localparam logic [4:0] OP_NOT  = 5'b01101;

endpackage

// File: rtl/alu.sv
// alu
// Combinational ALU of the CPU datapath.
// Ports:
//   A      in  DATA_W    first operand (register Y)
//   B      in  DATA_W    second operand (BusMuxOut)
//   op     in  5         operation select (codes in cpu_datapath_pkg)
//   IncPC  in  1         overrides op: result = B + 1
//   Cin    in  1         carry/borrow input for ADD and SUB
//   result out 2*DATA_W  upper half is always zero
// Build option: define DATAPATH_ROTATE_EN to implement ROR/ROL; without it
// those codes produce 0 like any unused code.
module alu #(
  parameter int DATA_W = cpu_datapath_pkg::DATA_W
) (
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [4:0]          op,
  input  logic                IncPC,
  input  logic                Cin,
  output logic [2*DATA_W-1:0] result
);
  import cpu_datapath_pkg::*;

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [4:0]        shamt;
  logic [DATA_W-1:0] cin_ext;
  logic [DATA_W-1:0] low;

  assign shamt   = B[4:0];
  assign cin_ext = {{(DATA_W-1){1'b0}}, Cin};

`ifdef DATAPATH_ROTATE_EN
  // Shifting a doubled copy of A yields the rotation in one half:
  // the low half for a right rotate, the high half for a left rotate.
  logic [2*DATA_W-1:0] rot_r;
  logic [2*DATA_W-1:0] rot_l;
  assign rot_r = {A, A} >> shamt;
  assign rot_l = {A, A} << shamt;
`endif

  always_comb begin
    low = '0;
    if (IncPC) begin
      low = B + ONE;
    end else begin
      case (op)
        OP_ADD:  low = A + B + cin_ext;
        OP_SUB:  low = A - B - cin_ext;
        OP_SHR:  low = A >> shamt;
        OP_SHRA: low = DATA_W'($signed(A) >>> shamt);
        OP_SHL:  low = A << shamt;
`ifdef DATAPATH_ROTATE_EN
        OP_ROR:  low = rot_r[DATA_W-1:0];
        OP_ROL:  low = rot_l[2*DATA_W-1:DATA_W];
`endif
        OP_OR:   low = A | B;
        OP_AND:  low = A & B;
        OP_NEG:  low = '0 - B;
        OP_NOT:  low = ~B;
        default: low = '0;
      endcase
    end
    result = {{DATA_W{1'b0}}, low};
  end

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath
// 32-bit single-bus CPU datapath: general registers R1..R15, special
// registers PC, IR, MAR, MDR, HI, LO, Y, Z (64-bit, split halves) and a
// combinational ALU, all linked by BusMuxOut. One micro-operation per clock.
// Ports:
//   Clock                    in  rising-edge clock
//   Clear                    in  asynchronous active-low reset
//   PCout..R4out             in  bus source selects (fixed priority)
//   MARin..LOin, R1in..R15in in  register load enables
//   ZHighIn, ZLowIn          in  load Z halves from the ALU result
//   IncPC, Cin, OR           in  ALU controls
//   Read                     in  MDR source: 1 = Mdatain, 0 = BusMuxOut
//   Mdatain                  in  memory read data
//   BusMuxOut                out current bus value
// Build option: DATAPATH_ROTATE_EN (see alu.sv).
module cpu_datapath #(
  parameter int DATA_W = cpu_datapath_pkg::DATA_W
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              PCout,
  input  logic              ZHighout,
  input  logic              Zlowout,
  input  logic              MDRout,
  input  logic              R2out,
  input  logic              R4out,
  input  logic              MARin,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              IRin,
  input  logic              Yin,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              R1in,
  input  logic              R2in,
  input  logic              R3in,
  input  logic              R4in,
  input  logic              R5in,
  input  logic              R6in,
  input  logic              R7in,
  input  logic              R8in,
  input  logic              R9in,
  input  logic              R10in,
  input  logic              R11in,
  input  logic              R12in,
  input  logic              R13in,
  input  logic              R14in,
  input  logic              R15in,
  input  logic              ZHighIn,
  input  logic              ZLowIn,
  input  logic              IncPC,
  input  logic              Read,
  input  logic              Cin,
  input  logic [4:0]        OR,
  input  logic [DATA_W-1:0] Mdatain,
  output logic [DATA_W-1:0] BusMuxOut
);

  logic [DATA_W-1:0]   pc, ir, mar, mdr, hi, lo, y, z_hi, z_lo;
  logic [DATA_W-1:0]   gpr [1:15];
  logic [15:1]         gpr_in;
  logic [2*DATA_W-1:0] alu_result;

  assign gpr_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in};

  // Fixed-priority bus source select; an idle bus reads as zero.
  always_comb begin
    BusMuxOut = '0;
    if      (PCout)    BusMuxOut = pc;
    else if (Zlowout)  BusMuxOut = z_lo;
    else if (ZHighout) BusMuxOut = z_hi;
    else if (MDRout)   BusMuxOut = mdr;
    else if (R2out)    BusMuxOut = gpr[2];
    else if (R4out)    BusMuxOut = gpr[4];
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .A      (y),
    .B      (BusMuxOut),
    .op     (OR),
    .IncPC  (IncPC),
    .Cin    (Cin),
    .result (alu_result)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 1; i <= 15; i++) gpr[i] <= '0;
    end else begin
      for (int i = 1; i <= 15; i++) begin
        if (gpr_in[i]) gpr[i] <= BusMuxOut;
      end
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc   <= '0;
      ir   <= '0;
      mar  <= '0;
      mdr  <= '0;
      hi   <= '0;
      lo   <= '0;
      y    <= '0;
      z_hi <= '0;
      z_lo <= '0;
    end else begin
      if (PCin)    pc   <= BusMuxOut;
      if (IRin)    ir   <= BusMuxOut;
      if (MARin)   mar  <= BusMuxOut;
      if (MDRin)   mdr  <= Read ? Mdatain : BusMuxOut;
      if (HIin)    hi   <= BusMuxOut;
      if (LOin)    lo   <= BusMuxOut;
      if (Yin)     y    <= BusMuxOut;
      if (ZHighIn) z_hi <= alu_result[2*DATA_W-1:DATA_W];
      if (ZLowIn)  z_lo <= alu_result[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath
// Self-checking bench for cpu_datapath: directed micro-operation sequences
// plus randomized ALU operations compared against a behavioural model.
module tb_cpu_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        PCout, ZHighout, Zlowout, MDRout, R2out, R4out;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic [15:1] r_in;
  logic        ZHighIn, ZLowIn, IncPC, Read, Cin;
  logic [4:0]  OR;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  cpu_datapath dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R2out(R2out), .R4out(R4out),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin),
    .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]), .R4in(r_in[4]),
    .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]), .R8in(r_in[8]),
    .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]), .R12in(r_in[12]),
    .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .IncPC(IncPC), .Read(Read), .Cin(Cin),
    .OR(OR), .Mdatain(Mdatain), .BusMuxOut(BusMuxOut)
  );

  // Behavioural reference: each operation written from its arithmetic meaning.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic inc);
    logic [31:0] r;
    int          s;
    longint      wide;
    s = int'(b % 32);
    if (inc) return b + 32'd1;
    case (op)
      5'd3:  begin wide = longint'(a) + longint'(b) + longint'(cin); r = wide[31:0]; end
      5'd4:  begin wide = longint'(a) - longint'(b) - longint'(cin); r = wide[31:0]; end
      5'd5:  r = a / (32'd1 << s);
      5'd6:  begin r = a; for (int k = 0; k < s; k++) r = {r[31], r[31:1]}; end
      5'd7:  r = a * (32'd1 << s);
`ifdef DATAPATH_ROTATE_EN
      5'd8:  begin r = a; for (int k = 0; k < s; k++) r = {r[0], r[31:1]}; end
      5'd9:  begin r = a; for (int k = 0; k < s; k++) r = {r[30:0], r[31]}; end
`endif
      5'd10: r = a | b;
      5'd11: r = a & b;
      5'd12: r = 32'd0 - b;
      5'd13: r = 32'hFFFF_FFFF ^ b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic clr_ctrl();
    PCout = 0; ZHighout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R4out = 0;
    MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; HIin = 0; LOin = 0;
    r_in = '0; ZHighIn = 0; ZLowIn = 0; IncPC = 0; Read = 0; Cin = 0;
    OR = 5'd0; Mdatain = 32'd0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    clr_ctrl(); Mdatain = v; Read = 1; MDRin = 1; step();
  endtask

  // Route a value through MDR into Y (which = 0), PC (1) or R[which-1] (2..16).
  task automatic load_reg(input int which, input logic [31:0] v);
    load_mdr(v);
    clr_ctrl(); MDRout = 1;
    if (which == 0) Yin = 1;
    else if (which == 1) PCin = 1;
    else r_in[which-1] = 1;
    step();
    clr_ctrl();
  endtask

  task automatic test_reset();
    clr_ctrl(); Clear = 0; #3;
    n_cmp++;
    if (BusMuxOut !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_bus actual=%h required=%h", BusMuxOut, 32'd0); end
    PCout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_pc actual=%h required=%h", BusMuxOut, 32'd0); end
    clr_ctrl();
    @(negedge Clock); Clear = 1;
  endtask

  task automatic test_register_load();
    load_mdr(32'h22);
    clr_ctrl(); MDRout = 1; r_in[2] = 1; step();
    clr_ctrl(); R2out = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'h22) begin n_fail++; $display("[TB] FAIL reg_load_r2 actual=%h required=%h", BusMuxOut, 32'h22); end
    clr_ctrl();
  endtask

  task automatic test_or_instr();
    load_reg(3, 32'h22); load_reg(5, 32'h24); load_reg(6, 32'h26);
    clr_ctrl(); R2out = 1; Yin = 1; step();
    clr_ctrl(); R4out = 1; OR = 5'b01010; ZLowIn = 1; ZHighIn = 1; step();
    clr_ctrl(); Zlowout = 1; r_in[5] = 1; step();
    clr_ctrl(); #1;
    n_cmp++;
    if (dut.gpr[5] !== 32'h26) begin n_fail++; $display("[TB] FAIL or_r5 actual=%h required=%h", dut.gpr[5], 32'h26); end
    ZHighout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd0) begin n_fail++; $display("[TB] FAIL or_zhigh actual=%h required=%h", BusMuxOut, 32'd0); end
    clr_ctrl();
  endtask

  task automatic test_fetch();
    clr_ctrl(); PCin = 1; step();
    clr_ctrl(); PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1; step();
    clr_ctrl(); Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h4A92_0000; step();
    clr_ctrl(); MDRout = 1; IRin = 1; step();
    clr_ctrl(); PCout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd1) begin n_fail++; $display("[TB] FAIL fetch_pc actual=%h required=%h", BusMuxOut, 32'd1); end
    n_cmp++;
    if (dut.mar !== 32'd0) begin n_fail++; $display("[TB] FAIL fetch_mar actual=%h required=%h", dut.mar, 32'd0); end
    n_cmp++;
    if (dut.ir !== 32'h4A92_0000) begin n_fail++; $display("[TB] FAIL fetch_ir actual=%h required=%h", dut.ir, 32'h4A92_0000); end
    clr_ctrl();
  endtask

  task automatic test_add_carry();
    load_reg(0, 32'hFFFF_FFFF);
    load_mdr(32'd1);
    clr_ctrl(); MDRout = 1; OR = 5'b00011; Cin = 1; ZLowIn = 1; step();
    clr_ctrl(); Zlowout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd1) begin n_fail++; $display("[TB] FAIL add_carry actual=%h required=%h", BusMuxOut, 32'd1); end
    clr_ctrl();
  endtask

  task automatic test_bus_priority();
    load_reg(1, 32'd5);
    load_mdr(32'd9);
    clr_ctrl(); PCout = 1; MDRout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd5) begin n_fail++; $display("[TB] FAIL prio_pc_mdr actual=%h required=%h", BusMuxOut, 32'd5); end
    PCout = 0; R2out = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd9) begin n_fail++; $display("[TB] FAIL prio_mdr_r2 actual=%h required=%h", BusMuxOut, 32'd9); end
    clr_ctrl(); #1;
    n_cmp++;
    if (BusMuxOut !== 32'd0) begin n_fail++; $display("[TB] FAIL prio_idle actual=%h required=%h", BusMuxOut, 32'd0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    // Same register as source and destination keeps its old value.
    clr_ctrl(); PCout = 1; PCin = 1; step();
    clr_ctrl(); PCout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd5) begin n_fail++; $display("[TB] FAIL pc_self actual=%h required=%h", BusMuxOut, 32'd5); end
    // Two increments back to back.
    for (int k = 0; k < 2; k++) begin
      clr_ctrl(); PCout = 1; IncPC = 1; ZLowIn = 1; step();
      clr_ctrl(); Zlowout = 1; PCin = 1; step();
    end
    clr_ctrl(); PCout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd7) begin n_fail++; $display("[TB] FAIL pc_inc2 actual=%h required=%h", BusMuxOut, 32'd7); end
    // Multiple in-strobes capture the same bus value.
    v = $urandom;
    load_mdr(v);
    clr_ctrl(); MDRout = 1; r_in = '1; HIin = 1; LOin = 1; step();
    clr_ctrl(); #1;
    n_cmp++;
    if (dut.gpr[7] !== v) begin n_fail++; $display("[TB] FAIL multi_r7 actual=%h required=%h", dut.gpr[7], v); end
    n_cmp++;
    if (dut.gpr[15] !== v) begin n_fail++; $display("[TB] FAIL multi_r15 actual=%h required=%h", dut.gpr[15], v); end
    n_cmp++;
    if (dut.hi !== v) begin n_fail++; $display("[TB] FAIL multi_hi actual=%h required=%h", dut.hi, v); end
    R4out = 1; #1;
    n_cmp++;
    if (BusMuxOut !== v) begin n_fail++; $display("[TB] FAIL multi_r4 actual=%h required=%h", BusMuxOut, v); end
    clr_ctrl();
  endtask

  task automatic test_random_alu();
    logic [31:0] a, b, exp;
    logic [4:0]  op;
    logic        cin, inc;
    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      b   = $urandom;
      op  = (i < 14) ? 5'(i) : 5'($urandom_range(0, 31));
      cin = 1'($urandom_range(0, 1));
      inc = ($urandom_range(0, 9) == 0);
      exp = ref_alu(op, a, b, cin, inc);
      load_reg(0, a);
      load_mdr(b);
      clr_ctrl(); MDRout = 1; OR = op; Cin = cin; IncPC = inc; ZLowIn = 1; ZHighIn = 1; step();
      clr_ctrl(); Zlowout = 1; #1;
      n_cmp++;
      if (BusMuxOut !== exp) begin
        n_fail++;
        $display("[TB] FAIL alu_low op=%0d a=%h b=%h cin=%0b inc=%0b actual=%h required=%h",
                 op, a, b, cin, inc, BusMuxOut, exp);
      end
      Zlowout = 0; ZHighout = 1; #1;
      n_cmp++;
      if (BusMuxOut !== 32'd0) begin n_fail++; $display("[TB] FAIL alu_high op=%0d actual=%h required=%h", op, BusMuxOut, 32'd0); end
      clr_ctrl();
    end
  endtask

  task automatic test_async_reset();
    load_reg(0, 32'h1111_1111);
    load_reg(1, 32'h0000_0ABC);
    load_reg(3, 32'h3333_3333);
    clr_ctrl(); MDRout = 1; IRin = 1; MARin = 1; ZLowIn = 1; OR = 5'b01010; step();
    clr_ctrl();
    @(negedge Clock); #2;
    Clear = 0; #1;
    PCout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd0) begin n_fail++; $display("[TB] FAIL areset_pc actual=%h required=%h", BusMuxOut, 32'd0); end
    PCout = 0; Zlowout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd0) begin n_fail++; $display("[TB] FAIL areset_zlo actual=%h required=%h", BusMuxOut, 32'd0); end
    Zlowout = 0; MDRout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd0) begin n_fail++; $display("[TB] FAIL areset_mdr actual=%h required=%h", BusMuxOut, 32'd0); end
    MDRout = 0; R2out = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd0) begin n_fail++; $display("[TB] FAIL areset_r2 actual=%h required=%h", BusMuxOut, 32'd0); end
    n_cmp++;
    if (dut.y !== 32'd0) begin n_fail++; $display("[TB] FAIL areset_y actual=%h required=%h", dut.y, 32'd0); end
    n_cmp++;
    if (dut.ir !== 32'd0) begin n_fail++; $display("[TB] FAIL areset_ir actual=%h required=%h", dut.ir, 32'd0); end
    n_cmp++;
    if (dut.gpr[15] !== 32'd0) begin n_fail++; $display("[TB] FAIL areset_r15 actual=%h required=%h", dut.gpr[15], 32'd0); end
    clr_ctrl();
    @(negedge Clock); Clear = 1;
    // Resumes from zero: an increment of the cleared PC gives 1.
    clr_ctrl(); PCout = 1; IncPC = 1; ZLowIn = 1; step();
    clr_ctrl(); Zlowout = 1; #1;
    n_cmp++;
    if (BusMuxOut !== 32'd1) begin n_fail++; $display("[TB] FAIL areset_resume actual=%h required=%h", BusMuxOut, 32'd1); end
    clr_ctrl();
  endtask

  initial begin
    clr_ctrl();
    Clear = 0;
    test_reset();
    test_register_load();
    test_or_instr();
    test_fetch();
    test_add_carry();
    test_bus_priority();
    test_back_to_back();
    test_random_alu();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
